sign_applier: RTL
=================

Name: sign_applier

Overview:
- Consumer end of the sign-switcher count stream: reads 8-bit `{flip, count}` entries from the `count_out` FIFO.
- Expands each entry over the coefficient stream: passes `count` coefficients through and inverts the sign of the last one when `flip` is set.
- Sits after the coefficient FIFO and writes modified sign-magnitude coefficients to the downstream packer FIFO, with almost-full backpressure.

Parameters:
COEF_W, 12, coefficient width, sign-magnitude, bit [COEF_W-1] is sign
STAT_W, 16, width of statistics counter (optional feature only)

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
clk_en  in  1  global clock enable
count_in  in  8  entry {[7]:flip, [6:0]:count}
count_empty  in  1  empty flag of count FIFO
count_rd  out  1  read strobe to count FIFO
coef_in  in  COEF_W  coefficient from coefficient FIFO
coef_empty  in  1  empty flag of coefficient FIFO
coef_rd  out  1  read strobe to coefficient FIFO
coef_out_afull  in  1  almost-full of output FIFO
coef_out  out  COEF_W  modified coefficient
coef_out_wr  out  1  write strobe to output FIFO
err  out  1  sticky error flag
flip_count  out  STAT_W  number of signs flipped (optional feature only)

Behaviour:
- Interface conventions: clock is `clk`; reset is `rst`, synchronous and active-high. All registers update only when `clk_en`=1, except reset.
- FIFO read model: data is valid on the cycle after a `rd` with `~empty` and stays stable until the next `rd`. Internal flags track this: `count_valid` and `coef_valid` are set by (`rd` && `~empty`) and cleared when the data is consumed.
- Reset values: `coef_out`=0, `coef_out_wr`=0, `err`=0, state=FETCH, `rem`=0, `flip_r`=0, valid flags=0.
- While `rst`=1, `count_rd`=0 and `coef_rd`=0.
- States:
  - FETCH: if `count_valid` && `count_in[6:0]`!=0, latch `rem`<=`count_in[6:0]` and `flip_r`<=`count_in[7]`, clear `count_valid`, go to RUN.
  - FETCH, zero count: if `count_valid` && `count_in[6:0]`==0, discard the entry, set `err`, stay in FETCH.
  - RUN: `advance` = `coef_valid` && `~coef_out_afull` && `clk_en`.
    - On advance, `coef_out`<=`coef_in` with the sign bit XORed with (`flip_r` && `rem`==1); `rem`<=`rem`-1.
    - When `rem`==1 and advance, go to FETCH.
- `count_rd` = `clk_en` && `~rst` && `~count_valid`. This prefetches the next entry during RUN.
- `coef_rd` = `clk_en` && `~rst` && (`~coef_valid` || `advance`).
- `coef_out_wr` is registered: 1 exactly the cycle after each advance, otherwise 0. When `clk_en`=0 it is forced to 0 on the next edge.
- Latency: one cycle from advance to `coef_out` and `coef_out_wr`.
- Entry boundary: one-cycle bubble between the last coefficient of an entry and the first of the next, because FETCH always takes one cycle.
- Zero magnitude with flip: if `coef_in[COEF_W-2:0]`==0 and a flip applies, the sign is NOT inverted (output +0) and `err` is set.
- `count` range is 1..127; `rem` is 7 bits, so no wrap-around is possible.
- Simultaneous events:
  - Prefetch of the next entry in the same cycle as the last advance is allowed; FETCH consumes it on the following cycle.
  - A `coef_valid` set and clear in the same cycle (`rd` while advancing) keeps `coef_valid`=1.
- Backpressure: `coef_out_afull`=1 stalls in RUN with state, `rem` and `coef_out` held. Downstream FIFO headroom must be at least 2.
- Reset mid-operation returns to FETCH with everything cleared. Any FIFO word read in the cycle before reset is lost; upstream FIFOs are reset together.
- `err` clears only on reset.

Optional Feature:
- Macro: `SIGN_APPLIER_STATS_EN`.
- Defined: `flip_count` is a STAT_W-bit counter, reset to 0, incremented on each advance where the sign is actually inverted. It saturates at all-ones.
- Undefined: `flip_count` port tied to 0; no counter logic.

Test Plan:
- Entries {1,3},{0,2} and coefs +5,+7,+9,-4,+6 → `coef_out` sequence +5,+7,-9,-4,+6. `coef_out_wr` pulses 5 times, with a one-cycle gap after -9. `err`=0.
- Entry {1,1}, coef -0x7FF (COEF_W=12) → output +0x7FF. With STATS enabled, `flip_count`=1.
- Entry {0,0} then {1,1}, coef +3 → first entry discarded and `err`=1. Output -3.
- Entry {1,127}, 127 coefs all +1, `coef_out_afull` toggled every 3 cycles → exactly 127 writes. Only the 127th is -1; no write while afull.
- Entry {1,4}, reset asserted after 2 writes, then entry {0,2} with coefs +8,+9 → after reset, outputs +8,+9 unmodified. Outputs are 0 during reset.
- `clk_en` low for 5 cycles mid-entry {1,3} → `count_rd`, `coef_rd` and `coef_out_wr` stay 0 during the stall. The sequence resumes and the third coefficient is flipped.

Source files
------------

// File: rtl/sign_applier_if.sv
// sign_applier_if: count/coefficient FIFO read ports and output FIFO write port of sign_applier
interface sign_applier_if #(
  parameter int COEF_W = 12
);
  logic [7:0] count_in;
  logic count_empty;
  logic count_rd;
  logic [COEF_W-1:0] coef_in;
  logic coef_empty;
  logic coef_rd;
  logic coef_out_afull;
  logic [COEF_W-1:0] coef_out;
  logic coef_out_wr;
  modport master (
    output count_in, count_empty, coef_in, coef_empty, coef_out_afull,
    input count_rd, coef_rd, coef_out, coef_out_wr
  );
  modport slave (
    input count_in, count_empty, coef_in, coef_empty, coef_out_afull,
    output count_rd, coef_rd, coef_out, coef_out_wr
  );
endinterface

// File: rtl/sign_applier.sv
// sign_applier: expands {flip,count} entries over the coefficient stream, inverting the sign of an entry's last coefficient when flip is set (SIGN_APPLIER_STATS_EN enables flip_count)
module sign_applier #(
  parameter int COEF_W = 12,
  parameter int STAT_W = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clk_en,
  sign_applier_if.slave bus,
  output logic err,
  output logic [STAT_W-1:0] flip_count
);
  typedef enum logic {FETCH, RUN} state_t;
  state_t state_q, state_d;
  logic count_valid_q, count_valid_d, coef_valid_q, coef_valid_d;
  logic flip_q, flip_d, wr_q, wr_d, err_q, err_d;
  logic [6:0] rem_q, rem_d;
  logic [COEF_W-1:0] out_q, out_d;
  logic fetch, nz, advance, last, zero_mag, inv;
  assign fetch = clk_en && state_q == FETCH && count_valid_q;
  assign nz = bus.count_in[6:0] != 7'd0;
  assign advance = clk_en && state_q == RUN && coef_valid_q && !bus.coef_out_afull;
  assign last = rem_q == 7'd1;
  assign zero_mag = bus.coef_in[COEF_W-2:0] == '0;
  assign inv = advance && flip_q && last && !zero_mag;
  assign bus.count_rd = clk_en && !rst && !count_valid_q;
  assign bus.coef_rd = clk_en && !rst && (!coef_valid_q || advance);
  assign bus.coef_out = out_q;
  assign bus.coef_out_wr = wr_q;
  assign err = err_q;
  always_comb begin
    count_valid_d = (count_valid_q && !fetch) || (bus.count_rd && !bus.count_empty);
    coef_valid_d = (coef_valid_q && !advance) || (bus.coef_rd && !bus.coef_empty);
    state_d = (fetch && nz) ? RUN : (advance && last) ? FETCH : state_q;
    rem_d = (fetch && nz) ? bus.count_in[6:0] : advance ? rem_q - 7'd1 : rem_q;
    flip_d = (fetch && nz) ? bus.count_in[7] : flip_q;
    out_d = advance ? {bus.coef_in[COEF_W-1] ^ inv, bus.coef_in[COEF_W-2:0]} : out_q;
    wr_d = advance;
    err_d = err_q || (fetch && !nz) || (advance && flip_q && last && zero_mag);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      count_valid_q <= 1'b0;
      coef_valid_q <= 1'b0;
      rem_q <= '0;
      flip_q <= 1'b0;
      out_q <= '0;
      wr_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      count_valid_q <= count_valid_d;
      coef_valid_q <= coef_valid_d;
      rem_q <= rem_d;
      flip_q <= flip_d;
      out_q <= out_d;
      wr_q <= wr_d;
      err_q <= err_d;
    end
  end
`ifdef SIGN_APPLIER_STATS_EN
  logic [STAT_W-1:0] flip_count_q, flip_count_d;
  always_comb flip_count_d = (inv && !(&flip_count_q)) ? flip_count_q + 1'b1 : flip_count_q;
  always_ff @(posedge clk) flip_count_q <= rst ? '0 : flip_count_d;
  assign flip_count = flip_count_q;
`else
  assign flip_count = '0;
`endif
endmodule
